// File: rtl/apb_biu_pkg.sv
// apb_biu_pkg
// Shared definitions for the APB-to-BIU multi-channel bridge:
//   - state_t : bridge FSM state encoding (IDLE, ACCESS, DONE)
//   - chw_f   : width of the channel index field for a given channel count
package apb_biu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Channel index width: clog2(n), but never narrower than one bit so a
    // single-channel build still has a legal field.
    function automatic int chw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_biu_tmo.sv
// apb_biu_tmo
// Wait counter for a BIU access. Cleared when an access starts, counts the
// cycles spent waiting, and flags expiry once TIMEOUT wait cycles have been
// used (expired is high during the last allowed cycle). TIMEOUT=0 builds no
// counter and the output never asserts.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  restart the count at zero
//   en      in  count this cycle
//   expired out current cycle is the last allowed wait cycle
module apb_biu_tmo #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr, en};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_reg;

            // Holds at LAST so the count can never wrap back to zero.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg <= '0;
                end else if (en && (cnt_reg != LAST)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign expired = (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_biu_mc.sv
// apb_biu_mc
// APB slave that forwards each transfer to one of NCH BIU channels selected
// by an address field, waits for that channel's accept (or a timeout) and
// then completes the APB access phase.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   apb_paddr/psel/penable/pwrite/pwdata/pstrb   APB request
//   apb_prdata               registered read data
//   apb_pready, apb_pslverr  completion and error (DONE state only)
//   biu_addr, biu_rnw, biu_wdata, biu_wstrb      latched request, shared
//   biu_enable               one-hot channel request during ACCESS
//   biu_rdata                packed per-channel read data
//   biu_accept               per-channel completion
module apb_biu_mc
    import apb_biu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NCH        = 4,
    parameter int CH_LSB     = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     apb_paddr,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic                      apb_pwrite,
    input  logic [DATA_WIDTH-1:0]     apb_pwdata,
    input  logic [DATA_WIDTH/8-1:0]   apb_pstrb,
    output logic [DATA_WIDTH-1:0]     apb_prdata,
    output logic                      apb_pready,
    output logic                      apb_pslverr,
    output logic [ADDR_WIDTH-1:0]     biu_addr,
    output logic [NCH-1:0]            biu_enable,
    output logic                      biu_rnw,
    output logic [DATA_WIDTH-1:0]     biu_wdata,
    output logic [DATA_WIDTH/8-1:0]   biu_wstrb,
    input  logic [NCH*DATA_WIDTH-1:0] biu_rdata,
    input  logic [NCH-1:0]            biu_accept
);

    localparam int CHW  = chw_f(NCH);
    localparam int SW   = DATA_WIDTH / 8;
    localparam int IDXW = ADDR_WIDTH - CH_LSB;
    localparam logic [IDXW-1:0] NCH_IDX = IDXW'(NCH);

    state_t                state_reg, state_next;
    logic [CHW-1:0]        ch_reg;
    logic                  err_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  rnw_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [SW-1:0]         wstrb_reg;
    logic [DATA_WIDTH-1:0] prdata_reg;

    logic                  setup;
    logic                  setup_ok;
    logic [NCH-1:0]        sel_vec;
    logic                  accept_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  tmo_clr;
    logic                  tmo_en;
    logic                  tmo_expired;

    assign setup = apb_psel && !apb_penable;

    // The whole field above CH_LSB is compared against NCH, not only the
    // CHW-bit index, so an address whose channel number lies beyond the
    // decoded field (e.g. channel 5 with 4 channels) is rejected rather
    // than aliased onto a real channel.
    assign setup_ok = (apb_paddr[ADDR_WIDTH-1:CH_LSB] < NCH_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_sel
            assign sel_vec[gi]    = (ch_reg == CHW'(gi));
            assign biu_enable[gi] = (state_reg == ST_ACCESS) && sel_vec[gi];
        end
    endgenerate

    // Only the selected channel's accept counts.
    assign accept_sel = |(biu_accept & sel_vec);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_vec[i]) begin
                rdata_sel = biu_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    apb_biu_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next  = state_reg;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (setup) begin
                    tmo_clr    = 1'b1;
                    state_next = setup_ok ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                // Accept is tested first so it wins over a same-cycle expiry.
                if (accept_sel) begin
                    state_next = ST_DONE;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!apb_psel) begin
                    state_next = ST_IDLE;
                end else if (apb_penable) begin
                    apb_pready  = 1'b1;
                    apb_pslverr = err_reg;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            ch_reg     <= '0;
            err_reg    <= 1'b0;
            addr_reg   <= '0;
            rnw_reg    <= 1'b1;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            prdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (setup) begin
                        addr_reg  <= apb_paddr;
                        rnw_reg   <= !apb_pwrite;
                        wdata_reg <= apb_pwdata;
                        wstrb_reg <= apb_pwrite ? apb_pstrb : '0;
                        ch_reg    <= apb_paddr[CH_LSB +: CHW];
                        err_reg   <= !setup_ok;
                        if (!setup_ok) begin
                            prdata_reg <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (accept_sel) begin
                        err_reg <= 1'b0;
                        if (rnw_reg) begin
                            prdata_reg <= rdata_sel;
                        end
                    end else if (tmo_expired) begin
                        err_reg    <= 1'b1;
                        prdata_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign apb_prdata = prdata_reg;
    assign biu_addr   = addr_reg;
    assign biu_rnw    = rnw_reg;
    assign biu_wdata  = wdata_reg;
    assign biu_wstrb  = wstrb_reg;

endmodule

// File: tb/tb_apb_biu_mc.sv
// tb_apb_biu_mc
// Directed transfers against apb_biu_mc (4 channels, channel field at bit 12,
// 16-cycle timeout). A transaction-level model predicts, for the current
// transfer, which cycles carry a channel request and which cycle completes;
// a per-cycle compare process checks the DUT against it, and the directed
// sequence adds hand-computed literal expectations.
module tb_apb_biu_mc;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NCH     = 4;
    localparam int CH_LSB  = 12;
    localparam int TIMEOUT = 16;
    localparam int TIED    = -2;   // accept held high for the whole transfer
    localparam int NEVER   = -1;   // accept never raised

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     apb_paddr;
    logic              apb_psel, apb_penable, apb_pwrite;
    logic [DW-1:0]     apb_pwdata;
    logic [DW/8-1:0]   apb_pstrb;
    logic [DW-1:0]     apb_prdata;
    logic              apb_pready, apb_pslverr;
    logic [AW-1:0]     biu_addr;
    logic [NCH-1:0]    biu_enable;
    logic              biu_rnw;
    logic [DW-1:0]     biu_wdata;
    logic [DW/8-1:0]   biu_wstrb;
    logic [NCH*DW-1:0] biu_rdata;
    logic [NCH-1:0]    biu_accept;

    apb_biu_mc #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NCH        (NCH),
        .CH_LSB     (CH_LSB),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .apb_paddr   (apb_paddr),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_pstrb   (apb_pstrb),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr),
        .biu_addr    (biu_addr),
        .biu_enable  (biu_enable),
        .biu_rnw     (biu_rnw),
        .biu_wdata   (biu_wdata),
        .biu_wstrb   (biu_wstrb),
        .biu_rdata   (biu_rdata),
        .biu_accept  (biu_accept)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int en_hi = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (|biu_enable) en_hi <= en_hi + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- transaction model ----------------
    logic [DW-1:0] rd_mem [NCH];
    int            m_t     = -1000;
    int            m_nacc  = 0;
    int            m_abort = 1 << 30;
    int            m_ch    = 0;
    logic          m_err   = 1'b0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_prdata = '0;
    logic [3:0]    m_strb  = '0;

    // Predicts one transfer whose setup phase is in the current cycle.
    task automatic model_start(input logic [AW-1:0] addr, input logic wr,
                               input logic [DW-1:0] wd, input logic [3:0] strb,
                               input int dly);
        m_t     = cyc;
        m_abort = 1 << 30;
        m_addr  = addr;
        m_wr    = wr;
        m_wdata = wd;
        m_strb  = wr ? strb : 4'b0;
        m_ch    = int'(addr >> CH_LSB);
        if (m_ch >= NCH) begin
            m_nacc = 0;       m_err = 1'b1;
        end else if (dly == TIED) begin
            m_nacc = 1;       m_err = 1'b0;
        end else if (dly >= 0 && dly < TIMEOUT) begin
            m_nacc = dly + 1; m_err = 1'b0;
        end else begin
            m_nacc = TIMEOUT; m_err = 1'b1;
        end
        if (m_err) m_prdata = '0;
        else       m_prdata = rd_mem[m_ch];
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic       in_acc, is_done;
        logic [3:0] e_en;
        if (chk_on) begin
            in_acc  = (cyc > m_t) && (cyc <= m_t + m_nacc) && (cyc <= m_abort);
            is_done = (cyc == m_t + m_nacc + 1) && (cyc <= m_abort);
            e_en    = in_acc ? 4'(1 << m_ch) : 4'b0;
            chk("biu_enable", biu_enable, e_en);
            chk("apb_pready", apb_pready, is_done);
            chk("apb_pslverr", apb_pslverr, is_done && m_err);
            if (in_acc) begin
                chk("biu_addr", biu_addr, m_addr);
                chk("biu_rnw", biu_rnw, !m_wr);
                chk("biu_wstrb", biu_wstrb, m_strb);
                if (m_wr) chk("biu_wdata", biu_wdata, m_wdata);
            end
            if (is_done && (!m_wr || m_err)) chk("apb_prdata", apb_prdata, m_prdata);
        end
    end

    // ---------------- stimulus ----------------
    // Setup phase in the next cycle, then access phase held until pready.
    // Returns at the negedge of the completing cycle with psel still high,
    // so a following call issues its setup back-to-back.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wd, input logic [3:0] strb,
                        input int dly, input logic [3:0] noise,
                        output int t_set, output int t_rdy,
                        output logic [DW-1:0] rd, output logic err);
        int         ch;
        logic [3:0] sel;
        ch    = int'(addr >> CH_LSB);
        sel   = (ch < NCH) ? 4'(1 << ch) : 4'b0;
        rd    = '0;
        err   = 1'b0;
        t_rdy = -1;
        @(posedge clk); #1;
        apb_paddr   = addr;
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = wr;
        apb_pwdata  = wd;
        apb_pstrb   = strb;
        biu_accept  = (noise & ~sel) | ((dly == TIED) ? sel : 4'b0);
        model_start(addr, wr, wd, strb, dly);
        t_set = cyc;
        for (int k = 0; k < 40 && t_rdy < 0; k++) begin
            @(posedge clk); #1;
            apb_penable = 1'b1;
            biu_accept  = (noise & ~sel) | ((dly == TIED || dly == k) ? sel : 4'b0);
            @(negedge clk);
            if (apb_pready) begin
                t_rdy = cyc;
                rd    = apb_prdata;
                err   = apb_pslverr;
            end
        end
        if (t_rdy < 0) chk("pready_wait", 1'b0, 1'b1);
        $display("txn addr=%08h %s lat=%0d slverr=%0b prdata=%08h",
                 addr, wr ? "WR" : "RD", t_rdy - t_set, err, rd);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            apb_psel    = 1'b0;
            apb_penable = 1'b0;
            biu_accept  = '0;
        end
    endtask

    initial begin
        int            ts, tr, e0;
        logic [DW-1:0] rd;
        logic          err;

        rd_mem[0] = 32'h0A0B_0C0D;
        rd_mem[1] = 32'h1111_1111;
        rd_mem[2] = 32'hFEFE_FAFA;
        rd_mem[3] = 32'h3333_3333;
        biu_rdata = {32'h3333_3333, 32'hFEFE_FAFA, 32'h1111_1111, 32'h0A0B_0C0D};

        rst = 1'b1; apb_paddr = '0; apb_psel = 1'b0; apb_penable = 1'b0;
        apb_pwrite = 1'b0; apb_pwdata = '0; apb_pstrb = '0; biu_accept = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata",  apb_prdata,  32'h0);
        chk("rst_pready",  apb_pready,  1'b0);
        chk("rst_pslverr", apb_pslverr, 1'b0);
        chk("rst_enable",  biu_enable,  4'b0);
        chk("rst_addr",    biu_addr,    32'h0);
        chk("rst_rnw",     biu_rnw,     1'b1);
        chk("rst_wdata",   biu_wdata,   32'h0);
        chk("rst_wstrb",   biu_wstrb,   4'b0);
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_on = 1'b1;
        idle(1);

        // Read channel 2, accept tied high: minimum latency.
        e0 = en_hi;
        xfer(32'h0000_200C, 1'b0, 32'h0, 4'hF, TIED, 4'b0000, ts, tr, rd, err);
        chk("r2_latency", tr - ts, 2);
        chk("r2_prdata", rd, 32'hFEFE_FAFA);
        chk("r2_slverr", err, 1'b0);
        chk("r2_en_cycles", en_hi - e0, 1);
        idle(1);

        // Write channel 1, accept after 3 wait cycles.
        xfer(32'h0000_100C, 1'b1, 32'hF1F2_F3F4, 4'b0101, 3, 4'b0000, ts, tr, rd, err);
        chk("w1_latency", tr - ts, 5);
        chk("w1_slverr", err, 1'b0);
        chk("w1_wdata", biu_wdata, 32'hF1F2_F3F4);
        chk("w1_wstrb", biu_wstrb, 4'b0101);
        chk("w1_rnw", biu_rnw, 1'b0);
        idle(2);

        // Read channel 3 never accepted; other channels' accepts must be ignored.
        e0 = en_hi;
        xfer(32'h0000_3000, 1'b0, 32'h0, 4'hF, NEVER, 4'b0111, ts, tr, rd, err);
        chk("tmo_latency", tr - ts, 17);
        chk("tmo_slverr", err, 1'b1);
        chk("tmo_prdata", rd, 32'h0);
        chk("tmo_en_cycles", en_hi - e0, 16);
        idle(1);

        // Channel 5 does not exist.
        e0 = en_hi;
        xfer(32'h0000_5000, 1'b0, 32'h0, 4'hF, TIED, 4'b1111, ts, tr, rd, err);
        chk("bad_latency", tr - ts, 1);
        chk("bad_slverr", err, 1'b1);
        chk("bad_en_cycles", en_hi - e0, 0);

        // Back-to-back: read ch1, write ch3, read ch0 with no idle cycles.
        xfer(32'h0000_1004, 1'b0, 32'h0, 4'hF, 0, 4'b0000, ts, tr, rd, err);
        chk("bb1_prdata", rd, 32'h1111_1111);
        xfer(32'h0000_3010, 1'b1, 32'hCAFE_0001, 4'b1000, 1, 4'b0000, ts, tr, rd, err);
        chk("bb2_latency", tr - ts, 3);
        xfer(32'h0000_0020, 1'b0, 32'h0, 4'hF, 2, 4'b1110, ts, tr, rd, err);
        chk("bb3_prdata", rd, 32'h0A0B_0C0D);
        idle(1);

        // Reset in the middle of an ACCESS wait.
        @(posedge clk); #1;
        apb_paddr = 32'h0000_3000; apb_psel = 1'b1; apb_penable = 1'b0;
        apb_pwrite = 1'b0; biu_accept = '0;
        model_start(32'h0000_3000, 1'b0, 32'h0, 4'hF, NEVER);
        repeat (3) begin @(posedge clk); #1; apb_penable = 1'b1; end
        rst     = 1'b1;
        m_abort = cyc;
        @(posedge clk); #1;
        rst = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0;
        @(negedge clk);
        chk("mid_rst_enable", biu_enable, 4'b0);
        chk("mid_rst_pready", apb_pready, 1'b0);
        chk("mid_rst_rnw", biu_rnw, 1'b1);
        $display("txn addr=00003000 RD reset during access");
        xfer(32'h0000_0000, 1'b0, 32'h0, 4'hF, 1, 4'b0000, ts, tr, rd, err);
        chk("post_rst_latency", tr - ts, 3);
        chk("post_rst_prdata", rd, 32'h0A0B_0C0D);
        chk("post_rst_slverr", err, 1'b0);
        idle(1);

        // Accept coincides with timeout expiry on channel 0: accept wins.
        xfer(32'h0000_0000, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, 4'b0000, ts, tr, rd, err);
        chk("edge_latency", tr - ts, 17);
        chk("edge_slverr", err, 1'b0);
        chk("edge_prdata", rd, 32'h0A0B_0C0D);
        idle(2);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
